control_unit: RTL and testbench

Instruction decoder and sequencing FSM for the 16-bit stack processor. It decodes the current instruction word into data-stack, return-stack, stack-source, PC-source, memory-write and PC-write controls for the datapath. A three-state FSM handles the start-up cycle after reset and a sticky halt.

---
 rtl/control_unit.sv | 142 ++++++++++++++
 tb/tb_control_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: instruction decoder and start/run/halt sequencer for the
// 16-bit stack processor. Decode is purely combinational in RUN; the FSM
// only gates the decode off during the start-up cycle and after a halt.
module control_unit (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] inst,
  output logic [2:0]  stackOP,
  output logic [1:0]  rStackOP,
  output logic [2:0]  stackControl,
  output logic [2:0]  PCControl,
  output logic        MemWrite,
  output logic        PCWrite
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Data-stack operations
  localparam logic [2:0] SOP_HOLD    = 3'd0;
  localparam logic [2:0] SOP_PUSH    = 3'd1;
  localparam logic [2:0] SOP_POP     = 3'd2;
  localparam logic [2:0] SOP_POP2PSH = 3'd3;
  localparam logic [2:0] SOP_REPLACE = 3'd4;
  localparam logic [2:0] SOP_SWAP    = 3'd5;
  localparam logic [2:0] SOP_DUP     = 3'd6;
  localparam logic [2:0] SOP_POP2    = 3'd7;

  // Return-stack operations
  localparam logic [1:0] ROP_HOLD = 2'd0;
  localparam logic [1:0] ROP_PUSH = 2'd1;
  localparam logic [1:0] ROP_POP  = 2'd2;

  // Stack-top source selects
  localparam logic [2:0] SRC_ADD  = 3'd0;
  localparam logic [2:0] SRC_SUB  = 3'd1;
  localparam logic [2:0] SRC_AND  = 3'd2;
  localparam logic [2:0] SRC_OR   = 3'd3;
  localparam logic [2:0] SRC_NOT  = 3'd4;
  localparam logic [2:0] SRC_IMM  = 3'd5;
  localparam logic [2:0] SRC_MEM  = 3'd6;
  localparam logic [2:0] SRC_RTOP = 3'd7;

  // Next-PC selects
  localparam logic [2:0] PC_INC    = 3'd0;
  localparam logic [2:0] PC_JUMP   = 3'd1;
  localparam logic [2:0] PC_BRZ    = 3'd2;
  localparam logic [2:0] PC_CALL   = 3'd3;
  localparam logic [2:0] PC_RETURN = 3'd4;

  localparam logic [3:0] OP_HALT = 4'h8;

  state_t      state_r;
  state_t      next_state_s;
  logic [3:0]  opcode_s;
  logic [3:0]  funct_s;
  logic        unused_s;

  assign opcode_s = inst[15:12];
  assign funct_s  = inst[3:0];
  // The immediate field is consumed by the datapath, not by the decoder.
  assign unused_s = &{1'b0, inst[11:4]};

  // State register: reset holds START; a halt is sticky until reset.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r <= ST_START;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = ST_START;
    case (state_r)
      ST_START: next_state_s = ST_RUN;
      ST_RUN: begin
        if (opcode_s == OP_HALT) begin
          next_state_s = ST_HALT;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_HALT:  next_state_s = ST_HALT;
      default:  next_state_s = ST_START;
    endcase
  end

  // Output decode: all zero outside RUN, otherwise decode of the live instruction.
  always_comb begin
    stackOP      = SOP_HOLD;
    rStackOP     = ROP_HOLD;
    stackControl = SRC_ADD;
    PCControl    = PC_INC;
    MemWrite     = 1'b0;
    PCWrite      = 1'b0;
    if (state_r == ST_RUN) begin
      PCWrite = 1'b1;
      case (opcode_s)
        4'h0: begin
          case (funct_s)
            4'h1: begin stackOP = SOP_POP2PSH; stackControl = SRC_ADD; end
            4'h2: begin stackOP = SOP_POP2PSH; stackControl = SRC_SUB; end
            4'h3: begin stackOP = SOP_POP2PSH; stackControl = SRC_AND; end
            4'h4: begin stackOP = SOP_POP2PSH; stackControl = SRC_OR;  end
            4'h5: begin stackOP = SOP_REPLACE; stackControl = SRC_NOT; end
            4'h6: stackOP = SOP_DUP;
            4'h7: stackOP = SOP_POP;
            4'h8: stackOP = SOP_SWAP;
            4'h9: stackOP = SOP_POP2;
            4'hA: begin stackOP = SOP_POP; rStackOP = ROP_PUSH; end
            4'hB: begin
              stackOP      = SOP_PUSH;
              stackControl = SRC_RTOP;
              rStackOP     = ROP_POP;
            end
            default: stackOP = SOP_HOLD;
          endcase
        end
        4'h1: begin stackOP = SOP_PUSH;    stackControl = SRC_IMM; end
        4'h2: begin stackOP = SOP_REPLACE; stackControl = SRC_MEM; end
        4'h3: begin stackOP = SOP_POP2;    MemWrite = 1'b1; end
        4'h4: PCControl = PC_JUMP;
        // TOS is consumed whether or not the branch is taken.
        4'h5: begin PCControl = PC_BRZ; stackOP = SOP_POP; end
        // The datapath pushes PC+1 on the return stack when PCControl is CALL.
        4'h6: begin PCControl = PC_CALL; rStackOP = ROP_PUSH; end
        4'h7: begin PCControl = PC_RETURN; rStackOP = ROP_POP; end
        // Halt cycle holds the PC on the halt instruction.
        4'h8: PCWrite = 1'b0;
        default: PCWrite = 1'b1;
      endcase
    end else begin
      PCWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit. Inputs change just after
// the rising edge; outputs are checked on the falling edge.
module tb_control_unit;

  logic        CLK;
  logic        reset;
  logic [15:0] inst;
  logic [2:0]  stackOP;
  logic [1:0]  rStackOP;
  logic [2:0]  stackControl;
  logic [2:0]  PCControl;
  logic        MemWrite;
  logic        PCWrite;

  int tests_run = 0;
  int tests_failed = 0;

  control_unit dut (
    .CLK          (CLK),
    .reset        (reset),
    .inst         (inst),
    .stackOP      (stackOP),
    .rStackOP     (rStackOP),
    .stackControl (stackControl),
    .PCControl    (PCControl),
    .MemWrite     (MemWrite),
    .PCWrite      (PCWrite)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare all outputs at once: {stackOP, rStackOP, stackControl, PCControl, MemWrite, PCWrite}
  task automatic check(input string tag, input logic [2:0] sop, input logic [1:0] rop,
                       input logic [2:0] sc, input logic [2:0] pcc, input logic mw,
                       input logic pw);
    logic [12:0] got;
    logic [12:0] exp;
    got = {stackOP, rStackOP, stackControl, PCControl, MemWrite, PCWrite};
    exp = {sop, rop, sc, pcc, mw, pw};
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed sop=%0d rop=%0d sc=%0d pcc=%0d mw=%0d pw=%0d expected sop=%0d rop=%0d sc=%0d pcc=%0d mw=%0d pw=%0d",
             tag, stackOP, rStackOP, stackControl, PCControl, MemWrite, PCWrite,
             sop, rop, sc, pcc, mw, pw);
    end
  endtask

  // Advance one clock, apply a new instruction, check on the falling edge.
  task automatic step(input string tag, input logic [15:0] i, input logic [2:0] sop,
                      input logic [1:0] rop, input logic [2:0] sc, input logic [2:0] pcc,
                      input logic mw, input logic pw);
    @(posedge CLK);
    #1 inst = i;
    @(negedge CLK);
    check(tag, sop, rop, sc, pcc, mw, pw);
  endtask

  initial begin
    reset = 1'b0;
    inst  = 16'h1005;
    #3;
    check("reset_low", 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    check("reset_low_edge", 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("start_cycle", 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge CLK);
    check("first_run_push", 3'd1, 2'd0, 3'd5, 3'd0, 1'b0, 1'b1);

    // Function sweep under opcode 0
    step("f0_nop",   16'h0000, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    step("f1_add",   16'h0001, 3'd3, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    step("f2_sub",   16'h0002, 3'd3, 2'd0, 3'd1, 3'd0, 1'b0, 1'b1);
    step("f3_and",   16'h0003, 3'd3, 2'd0, 3'd2, 3'd0, 1'b0, 1'b1);
    step("f4_or",    16'h0004, 3'd3, 2'd0, 3'd3, 3'd0, 1'b0, 1'b1);
    step("f5_not",   16'h0005, 3'd4, 2'd0, 3'd4, 3'd0, 1'b0, 1'b1);
    step("f6_dup",   16'h0006, 3'd6, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    step("f7_drop",  16'h0007, 3'd2, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    step("f8_swap",  16'h0008, 3'd5, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    step("f9_2drop", 16'h0009, 3'd7, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    step("fA_tor",   16'h000A, 3'd2, 2'd1, 3'd0, 3'd0, 1'b0, 1'b1);
    step("fB_rfrom", 16'h000B, 3'd1, 2'd2, 3'd7, 3'd0, 1'b0, 1'b1);

    // Other opcodes
    step("load",   16'h2000, 3'd4, 2'd0, 3'd6, 3'd0, 1'b0, 1'b1);
    step("store",  16'h3000, 3'd7, 2'd0, 3'd0, 3'd0, 1'b1, 1'b1);
    step("jump",   16'h4000, 3'd0, 2'd0, 3'd0, 3'd1, 1'b0, 1'b1);
    step("branch", 16'h5000, 3'd2, 2'd0, 3'd0, 3'd2, 1'b0, 1'b1);
    step("call",   16'h6000, 3'd0, 2'd1, 3'd0, 3'd3, 1'b0, 1'b1);
    step("return", 16'h7000, 3'd0, 2'd2, 3'd0, 3'd4, 1'b0, 1'b1);

    // Illegal opcodes and unused functions behave as nop
    step("illegal_9", 16'h9000, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    step("illegal_F", 16'hF123, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    step("f_F_nop",   16'h000F, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1);

    // Halt and its stickiness
    step("halt_cycle",   16'h8000, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    step("halted_push",  16'h1000, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    step("halted_store", 16'h3000, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);

    // Reset pulse leaves HALT through START
    inst  = 16'h1000;
    reset = 1'b0;
    #1;
    check("halt_reset_low", 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("restart_start", 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge CLK);
    check("restart_run", 3'd1, 2'd0, 3'd5, 3'd0, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle aborts a store
    step("store_pre_abort", 16'h3000, 3'd7, 2'd0, 3'd0, 3'd0, 1'b1, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_abort", 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    @(negedge CLK);
    check("after_abort_run", 3'd7, 2'd0, 3'd0, 3'd0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
